// File: rtl/slink_apb_ini.sv
// S-Link APB initiator: turns tunnelled READ/WRITE request packets into single
// APB master transfers and returns the matching response packet.
module slink_apb_ini #(
  parameter logic [7:0]  APB_READ_DT      = 8'h24,
  parameter logic [7:0]  APB_READ_RSP_DT  = 8'h25,
  parameter logic [7:0]  APB_WRITE_DT     = 8'h26,
  parameter logic [7:0]  APB_WRITE_RSP_DT = 8'h27,
  parameter int unsigned TIMEOUT_CYCLES   = 256
) (
  input  logic        apb_clk,
  input  logic        apb_reset_n,
  input  logic        enable,
  input  logic        l2a_valid,
  input  logic [87:0] l2a_data,
  output logic        l2a_accept,
  output logic        a2l_valid,
  output logic [56:0] a2l_data,
  input  logic        a2l_ready,
  output logic [31:0] apb_paddr,
  output logic        apb_pwrite,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic [31:0] apb_pwdata,
  output logic [3:0]  apb_pstrb,
  output logic [2:0]  apb_pprot,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pready,
  input  logic        apb_pslverr,
  output logic        invalid_req_pkt,
  output logic        apb_timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [1:0]    en_sync_q;
  logic [CW-1:0] tmo_cnt_q;
  logic [31:0]   paddr_q;
  logic [31:0]   pwdata_q;
  logic [3:0]    pstrb_q;
  logic          pwrite_q;
  logic          psel_q;
  logic          penable_q;
  logic          a2l_valid_q;
  logic [56:0]   rsp_q;
  logic          invalid_q;
  logic          timeout_q;

  logic          enable_sync;
  logic [7:0]    req_dt;
  logic          req_rd;
  logic          req_wr;
  logic          tmo_hit;
  logic          unused_wc;

  assign enable_sync = en_sync_q[1];
  assign req_dt      = l2a_data[7:0];
  assign req_rd      = (req_dt == APB_READ_DT);
  assign req_wr      = (req_dt == APB_WRITE_DT);
  assign unused_wc   = ^l2a_data[23:8];
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);
  assign l2a_accept  = (state_q == IDLE) && enable_sync && l2a_valid;

  // Write responses carry only SLVERR at bit 24; read responses carry RDATA too.
  function automatic logic [56:0] rsp_pkt(input logic wr, input logic [31:0] rdata,
                                          input logic err);
    if (wr) rsp_pkt = {32'h0, err, 16'd1, APB_WRITE_RSP_DT};
    else    rsp_pkt = {err, rdata, 16'd5, APB_READ_RSP_DT};
  endfunction

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      en_sync_q   <= 2'b00;
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      a2l_valid_q <= 1'b0;
      rsp_q       <= '0;
      invalid_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      en_sync_q <= {en_sync_q[0], enable};
      invalid_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (l2a_accept) begin
            if (req_rd || req_wr) begin
              paddr_q  <= l2a_data[55:24];
              pwrite_q <= req_wr;
              pwdata_q <= req_wr ? l2a_data[87:56] : 32'h0;
              pstrb_q  <= req_wr ? 4'hF : 4'h0;
              psel_q   <= 1'b1;
              state_q  <= SETUP;
            end else begin
              invalid_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= ACCESS;
        end
        // pready wins over the timeout when both land in the same cycle.
        ACCESS: begin
          if (apb_pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q       <= rsp_pkt(pwrite_q, pwrite_q ? 32'h0 : apb_prdata, apb_pslverr);
            a2l_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (tmo_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q       <= rsp_pkt(pwrite_q, 32'h0, 1'b1);
            a2l_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (a2l_ready || !enable_sync) begin
            a2l_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a2l_valid       = a2l_valid_q;
  assign a2l_data        = rsp_q;
  assign apb_paddr       = paddr_q;
  assign apb_pwrite      = pwrite_q;
  assign apb_psel        = psel_q;
  assign apb_penable     = penable_q;
  assign apb_pwdata      = pwdata_q;
  assign apb_pstrb       = pstrb_q;
  assign apb_pprot       = 3'b000;
  assign invalid_req_pkt = invalid_q;
  assign apb_timeout     = timeout_q;

endmodule
